// File: rtl/mem_arbiter.sv
// Two-master (icache/dcache) RAM arbiter: dcache has priority and holds the RAM for a block burst.
// Optional ACCESS completion counters per master are enabled with MEM_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | combinational arbitration, dcache over icache
// DLOCK | dcache block burst in progress, counter holds words already transferred
// ILOCK | icache request waiting on RAM, dcache cannot preempt
module mem_arbiter #(
    parameter int BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_STATS_EN
   ,output logic [31:0] dserved,
    output logic [31:0] iserved
`endif
);
    localparam int CW = $clog2(BLK_WORDS) + 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, DLOCK = 2'd1, ILOCK = 2'd2} state_t;

    state_t        r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          w_dreq, w_ready, w_sel_d, w_sel_i;

    assign w_dreq  = dREN | dWEN;
    assign w_ready = (ramstate == RAM_ACCESS);
    // Gating with nRST keeps the RAM idle and both masters stalled while reset is held.
    assign w_sel_d = nRST && w_dreq && (r_state == IDLE || r_state == DLOCK);
    assign w_sel_i = nRST && iREN && ((r_state == IDLE && !w_dreq) || r_state == ILOCK);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_sel_d && w_ready) begin
                    if (BLK_WORDS > 1) begin
                        w_next_state = DLOCK;
                        w_next_cnt   = CW'(1);
                    end
                end else if (w_sel_i && !w_ready) begin
                    w_next_state = ILOCK;
                end
            end
            DLOCK: begin
                if (!w_dreq) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (w_ready) begin
                    if (r_cnt + CW'(1) >= CW'(BLK_WORDS)) begin
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CW'(1);
                    end
                end
            end
            ILOCK: begin
                if (!iREN || w_ready) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        if (w_sel_d) begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = ~w_ready;
            dload    = ramload;
        end else if (w_sel_i) begin
            ramREN   = 1'b1;
            ramaddr  = iaddr;
            iwait    = ~w_ready;
            iload    = ramload;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] r_dserved, r_iserved;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dserved <= '0;
            r_iserved <= '0;
        end else begin
            if (w_sel_d && w_ready) r_dserved <= r_dserved + 32'd1;
            if (w_sel_i && w_ready) r_iserved <= r_iserved + 32'd1;
        end
    end

    assign dserved = r_dserved;
    assign iserved = r_iserved;
`endif

endmodule
